// File: rtl/v_iota_pkg.sv
// Shared vALU mask helpers: SEW encoding, elements-per-beat and mask lane selection.
package v_iota_pkg;

  localparam int unsigned LANES = 8;
  localparam int unsigned SEW_W = 2;

  localparam logic [SEW_W-1:0] SEW_8  = 2'd0;
  localparam logic [SEW_W-1:0] SEW_16 = 2'd1;
  localparam logic [SEW_W-1:0] SEW_32 = 2'd2;
  localparam logic [SEW_W-1:0] SEW_64 = 2'd3;

  typedef struct packed {
    logic [LANES-1:0] sel;
    logic [SEW_W-1:0] sew;
    logic             valid;
    logic             start;
    logic             last;
  } s0_t;

  function automatic logic [3:0] elems_per_beat(input logic [SEW_W-1:0] sew);
    return 4'd8 >> sew;
  endfunction

  // Mask bit of element i lives at lane i*2^sew; lanes past the element count read 0.
  function automatic logic [LANES-1:0] lane_select(input logic [LANES-1:0] m,
                                                   input logic [SEW_W-1:0] sew);
    logic [LANES-1:0] sel;
    logic [2:0]       idx;
    sel = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      idx = 3'(i << sew);
      if (4'(i) < elems_per_beat(sew)) sel[i] = m[idx];
    end
    return sel;
  endfunction

endpackage

// File: rtl/v_iota_prefix.sv
// Per-beat exclusive prefix sums of the selected mask bits, offset by base and packed at SEW.
module v_iota_prefix
  import v_iota_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic [LANES-1:0]       sel,
  input  logic [SEW_W-1:0]       sew,
  input  logic [COUNT_WIDTH-1:0] base,
  output logic [DATA_WIDTH-1:0]  vec_c,
  output logic [COUNT_WIDTH-1:0] total_c
);

  logic [3:0] run;
  logic [3:0] pc [LANES];

  always_comb begin
    run = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      pc[k] = run;
      run   = run + 4'(sel[k]);
    end
    total_c = COUNT_WIDTH'(run);
  end

  // Element values wrap at their own width by truncation.
  always_comb begin
    vec_c = '0;
    case (sew)
      SEW_8: begin
        for (int k = 0; k < 8; k++) vec_c[8*k +: 8] = 8'(base + COUNT_WIDTH'(pc[k]));
      end
      SEW_16: begin
        for (int k = 0; k < 4; k++) vec_c[16*k +: 16] = 16'(base + COUNT_WIDTH'(pc[k]));
      end
      SEW_32: begin
        for (int k = 0; k < 2; k++) vec_c[32*k +: 32] = 32'(base + COUNT_WIDTH'(pc[k]));
      end
      default: vec_c = DATA_WIDTH'(base);
    endcase
  end

endmodule

// File: rtl/v_iota.sv
// viota.m mask expander: two-stage pipeline turning mask beats into per-element prefix counts.
module v_iota
  import v_iota_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned MASK_WIDTH  = 8,
  parameter int unsigned SEW_WIDTH   = 2,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MASK_WIDTH-1:0] in_m0,
  input  logic                  in_valid,
  input  logic [SEW_WIDTH-1:0]  in_sew,
  input  logic                  in_start,
  input  logic                  in_end,
  output logic [DATA_WIDTH-1:0] out_vec,
  output logic                  out_valid,
  output logic                  out_end
);

  s0_t s0_d, s0_q;

  logic [DATA_WIDTH-1:0]  out_vec_d, out_vec_q;
  logic                   out_valid_d, out_valid_q;
  logic                   out_end_d, out_end_q;
  logic [COUNT_WIDTH-1:0] count_d, count_q;

  logic [COUNT_WIDTH-1:0] base_c;
  logic [DATA_WIDTH-1:0]  vec_c;
  logic [COUNT_WIDTH-1:0] total_c;

  // Stage 0: capture the lane-selected mask and framing of valid beats only.
  always_comb begin
    s0_d = '0;
    if (in_valid) begin
      s0_d.sel   = lane_select(in_m0, in_sew);
      s0_d.sew   = in_sew;
      s0_d.valid = 1'b1;
      s0_d.start = in_start;
      s0_d.last  = in_end;
    end
  end

  assign base_c = s0_q.start ? '0 : count_q;

  v_iota_prefix #(
    .DATA_WIDTH (DATA_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_prefix (
    .sel    (s0_q.sel),
    .sew    (s0_q.sew),
    .base   (base_c),
    .vec_c  (vec_c),
    .total_c(total_c)
  );

  // Stage 1: result beat plus running count, so beat N's total is beat N+1's base.
  always_comb begin
    out_vec_d   = '0;
    out_valid_d = 1'b0;
    out_end_d   = 1'b0;
    count_d     = count_q;
    if (s0_q.valid) begin
      out_vec_d   = vec_c;
      out_valid_d = 1'b1;
      out_end_d   = s0_q.last;
      count_d     = s0_q.last ? '0 : base_c + total_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q        <= '0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
      out_end_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      s0_q        <= s0_d;
      out_vec_q   <= out_vec_d;
      out_valid_q <= out_valid_d;
      out_end_q   <= out_end_d;
      count_q     <= count_d;
    end
  end

  assign out_vec   = out_vec_q;
  assign out_valid = out_valid_q;
  assign out_end   = out_end_q;

endmodule

// File: tb/tb_v_iota.sv
// Directed bench for v_iota: hand-computed viota.m results across SEW, framing, bubbles and reset.
module tb_v_iota;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_m0;
  logic        in_valid;
  logic [1:0]  in_sew;
  logic        in_start;
  logic        in_end;
  logic [63:0] out_vec;
  logic        out_valid;
  logic        out_end;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int idle_dirty = 0;

  logic [63:0] ov_q[$];
  logic        oe_q[$];
  int          oc_q[$];
  int          ic_q[$];

  v_iota dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_m0    (in_m0),
    .in_valid (in_valid),
    .in_sew   (in_sew),
    .in_start (in_start),
    .in_end   (in_end),
    .out_vec  (out_vec),
    .out_valid(out_valid),
    .out_end  (out_end)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Collect result beats mid-cycle; idle cycles must show all-zero outputs.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      ov_q.push_back(out_vec);
      oe_q.push_back(out_end);
      oc_q.push_back(cyc);
    end else if (out_vec !== 64'h0 || out_end !== 1'b0) begin
      idle_dirty++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic drive(input logic v, input logic [7:0] m, input logic [1:0] sew,
                       input logic s, input logic e);
    in_valid = v;
    in_m0    = m;
    in_sew   = sew;
    in_start = s;
    in_end   = e;
    if (v) ic_q.push_back(cyc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic flush;
    ov_q.delete();
    oe_q.delete();
    oc_q.delete();
    ic_q.delete();
  endtask

  task automatic get_out(output logic [63:0] v, output logic e, output int lat, output bit ok);
    if (ov_q.size() > 0 && ic_q.size() > 0) begin
      v   = ov_q.pop_front();
      e   = oe_q.pop_front();
      lat = oc_q.pop_front() - ic_q.pop_front();
      ok  = 1'b1;
    end else begin
      v   = 'x;
      e   = 1'bx;
      lat = -1;
      ok  = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; in_m0 = 8'h00; in_sew = 2'd0; in_start = 1'b0; in_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (out_vec !== 64'h0) begin n_bad++; $display("FAIL reset_vec: got %h want 0", out_vec); end
    n_cmp++;
    if (out_end !== 1'b0) begin n_bad++; $display("FAIL reset_end: got %b want 0", out_end); end
    rst_n = 1'b1;
    idle(2);
    flush();
  endtask

  task automatic test_single;
    logic [63:0] v; logic e; int lat; bit ok;
    drive(1'b1, 8'hB5, 2'd0, 1'b1, 1'b1);
    idle(4);
    get_out(v, e, lat, ok);
    n_cmp++;
    if (!ok || v !== 64'h0404030202010100) begin n_bad++; $display("FAIL single_vec: got %h want 0404030202010100", v); end
    n_cmp++;
    if (e !== 1'b1) begin n_bad++; $display("FAIL single_end: got %b want 1", e); end
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL single_latency: got %0d want 2", lat); end
    flush();
  endtask

  task automatic test_back_to_back;
    logic [63:0] v; logic e; int lat; bit ok;
    drive(1'b1, 8'hFF, 2'd0, 1'b1, 1'b0);
    drive(1'b1, 8'h00, 2'd0, 1'b0, 1'b1);
    idle(4);
    get_out(v, e, lat, ok);
    n_cmp++;
    if (!ok || v !== 64'h0706050403020100 || e !== 1'b0) begin
      n_bad++; $display("FAIL b2b_beat1: got %h end %b want 0706050403020100 end 0", v, e);
    end
    get_out(v, e, lat, ok);
    n_cmp++;
    if (!ok || v !== 64'h0808080808080808 || e !== 1'b1) begin
      n_bad++; $display("FAIL b2b_beat2: got %h end %b want 0808080808080808 end 1", v, e);
    end
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL b2b_latency: got %0d want 2", lat); end
    flush();
  endtask

  task automatic test_sew32(input int bubbles);
    logic [63:0] v; logic e; int lat; bit ok; int n_out;
    drive(1'b1, 8'h11, 2'd2, 1'b1, 1'b0);
    repeat (bubbles) drive(1'b0, 8'hFF, 2'd2, 1'b1, 1'b1);
    drive(1'b1, 8'h01, 2'd2, 1'b0, 1'b1);
    idle(4);
    n_out = ov_q.size();
    n_cmp++;
    if (n_out !== 2) begin n_bad++; $display("FAIL sew32_beats(bubbles=%0d): got %0d want 2", bubbles, n_out); end
    get_out(v, e, lat, ok);
    n_cmp++;
    if (!ok || v !== 64'h0000000100000000 || e !== 1'b0) begin
      n_bad++; $display("FAIL sew32_beat1(bubbles=%0d): got %h end %b want 0000000100000000 end 0", bubbles, v, e);
    end
    get_out(v, e, lat, ok);
    n_cmp++;
    if (!ok || v !== 64'h0000000300000002 || e !== 1'b1) begin
      n_bad++; $display("FAIL sew32_beat2(bubbles=%0d): got %h end %b want 0000000300000002 end 1", bubbles, v, e);
    end
    flush();
  endtask

  task automatic test_mixed_sew;
    logic [63:0] v; logic e; int lat; bit ok;
    drive(1'b1, 8'h5A, 2'd1, 1'b1, 1'b1);
    drive(1'b1, 8'h55, 2'd1, 1'b1, 1'b0);
    drive(1'b1, 8'h01, 2'd3, 1'b0, 1'b1);
    idle(4);
    get_out(v, e, lat, ok);
    n_cmp++;
    if (!ok || v !== 64'h0001000000000000) begin n_bad++; $display("FAIL sew16_lane_select: got %h want 0001000000000000", v); end
    get_out(v, e, lat, ok);
    n_cmp++;
    if (!ok || v !== 64'h0003000200010000) begin n_bad++; $display("FAIL sew16_prefix: got %h want 0003000200010000", v); end
    get_out(v, e, lat, ok);
    n_cmp++;
    if (!ok || v !== 64'h0000000000000004 || e !== 1'b1) begin
      n_bad++; $display("FAIL sew64_base: got %h end %b want 0000000000000004 end 1", v, e);
    end
    flush();
  endtask

  task automatic test_long_wrap;
    logic [63:0] v; logic e; int lat; bit ok; int n_out;
    for (int i = 0; i < 32; i++) drive(1'b1, 8'hFF, 2'd0, (i == 0), 1'b0);
    drive(1'b1, 8'h01, 2'd0, 1'b0, 1'b1);
    drive(1'b1, 8'h03, 2'd0, 1'b1, 1'b1);
    idle(4);
    n_out = ov_q.size();
    n_cmp++;
    if (n_out !== 34) begin n_bad++; $display("FAIL long_beats: got %0d want 34", n_out); end
    for (int i = 0; i < 31; i++) get_out(v, e, lat, ok);
    get_out(v, e, lat, ok);
    n_cmp++;
    if (!ok || v !== 64'hFFFEFDFCFBFAF9F8) begin n_bad++; $display("FAIL long_beat31: got %h want FFFEFDFCFBFAF9F8", v); end
    get_out(v, e, lat, ok);
    n_cmp++;
    if (!ok || v !== 64'h0101010101010100 || e !== 1'b1) begin
      n_bad++; $display("FAIL long_wrap: got %h end %b want 0101010101010100 end 1", v, e);
    end
    get_out(v, e, lat, ok);
    n_cmp++;
    if (!ok || v !== 64'h0202020202020100) begin n_bad++; $display("FAIL long_restart: got %h want 0202020202020100", v); end
    flush();
  endtask

  task automatic test_reset_mid;
    logic [63:0] v; logic e; int lat; bit ok; int n_out;
    drive(1'b1, 8'hFF, 2'd0, 1'b1, 1'b0);
    drive(1'b1, 8'hFF, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_vec !== 64'h0) begin
      n_bad++; $display("FAIL midreset_clear: got valid %b vec %h want 0 0", out_valid, out_vec);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    n_out = ov_q.size();
    n_cmp++;
    if (n_out !== 0) begin n_bad++; $display("FAIL midreset_inflight: got %0d beats want 0", n_out); end
    flush();
    drive(1'b1, 8'h0F, 2'd0, 1'b0, 1'b1);
    idle(4);
    get_out(v, e, lat, ok);
    n_cmp++;
    if (!ok || v !== 64'h0404040403020100 || e !== 1'b1) begin
      n_bad++; $display("FAIL midreset_base: got %h end %b want 0404040403020100 end 1", v, e);
    end
    flush();
  endtask

  task automatic test_idle_zero;
    n_cmp++;
    if (idle_dirty !== 0) begin n_bad++; $display("FAIL idle_outputs_zero: got %0d dirty cycles want 0", idle_dirty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sew32(0);
    test_sew32(3);
    test_mixed_sew();
    test_long_wrap();
    test_reset_mid();
    test_idle_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
